alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Shares one combinational 32-bit ALU between two requesters (e.g. address-calc unit and branch-compare unit of the multi-cycle MIPS datapath).
- Arbitrates with round-robin priority, latches operands and drives them to the external ALU instance.
- Captures result/zero and returns them to the winning requester with a one-cycle response pulse.
- Rejects illegal ALU control codes with an error flag instead of passing X results downstream.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU instance.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ctl  input  3  ALU control code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B
- req0_ready  output  1  requester 0 operation accepted this cycle
- req1_valid, req1_ctl, req1_a, req1_b, req1_ready  same as requester 0
- alu_ctl  output  3  registered control to the ALU
- alu_a  output  WIDTH  registered operand A to the ALU
- alu_b  output  WIDTH  registered operand B to the ALU
- alu_result  input  WIDTH  ALU result (combinational from alu_*)
- alu_zero  input  1  ALU zero flag
- rsp0_valid  output  1  one-cycle pulse, response for requester 0
- rsp1_valid  output  1  one-cycle pulse, response for requester 1
- rsp_result  output  WIDTH  captured result, shared by both responses
- rsp_zero  output  1  captured zero flag
- rsp_err  output  1  illegal ctl code; qualified by rspN_valid

Behaviour:
- FSM states and transitions:
  - IDLE: accepts a request; goes to EXEC on accept.
  - EXEC: operands driven to ALU; goes to RESP at the next edge.
  - RESP: response pulse; returns to IDLE.
- Throughput and latency:
  - One accept per 3 cycles maximum.
  - Accept at edge N, rspN_valid high during cycle N+2 only.
- Handshake:
  - reqN_ready is combinational and high only in IDLE, for the granted requester.
  - A transfer occurs when reqN_valid & reqN_ready are both high at a rising edge.
  - A requester holds valid/ctl/a/b stable until ready.
  - Dropping valid before ready is legal; no operation is issued.
- Arbitration:
  - Round-robin pointer `last` records the last served requester.
  - Single valid: that requester is granted.
  - Both valid: the requester other than `last` is granted.
  - `last` updates on accept only.
  - Reset sets last=1, so requester 0 wins the first tie.
  - At most one reqN_ready is high in any cycle.
- Operand registers:
  - On accept, the granted ctl/a/b load into alu_ctl/alu_a/alu_b.
  - The source id loads into `owner`.
  - alu_* hold their values until the next accept; they are not cleared on return to IDLE.
- Capture, at the EXEC->RESP edge:
  - Legal ctl: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_err<=0.
  - Illegal ctl (011,100,101): rsp_result<=0, rsp_zero<=0, rsp_err<=1. The ALU output is ignored.
  - rsp_result/zero/err hold until the next capture.
- Response: in RESP, rsp{owner}_valid=1 and the other rsp valid=0. Both rsp valids are 0 in IDLE and EXEC.
- Reset, including mid-operation:
  - Next state is IDLE; any in-flight operation is dropped and no response is issued.
  - All outputs go to 0: req*_ready (combinational, 0 in the reset cycle), alu_ctl=000, alu_a=0, alu_b=0, rsp*_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0.
- Simultaneous events: a new request arriving during EXEC/RESP waits; its ready rises in the next IDLE cycle.
- Width rules: no width conversion; all datapaths are WIDTH bits, and no arithmetic is performed in this block.

Test Plan:
- Reset then req0 ADD a=5 b=7 → req0_ready high in IDLE cycle; two cycles later rsp0_valid=1 for one cycle, rsp_result=12, rsp_zero=0, rsp_err=0, rsp1_valid=0.
- Both valid every cycle after reset, req0 SUB 9-9 and req1 SLT 3<4 → grant order 0,1,0,1 at 3-cycle spacing. req0 responses give result 0, zero=1; req1 responses give result 1, zero=0.
- req1 ctl=3'b100 a=1 b=1 → rsp1_valid pulse with rsp_err=1, rsp_result=0, rsp_zero=0; the next legal op returns rsp_err=0.
- reset asserted during EXEC of a req0 OR → no rsp0_valid ever; all outputs 0 the cycle after. A tie immediately after reset grants req0 first.
- req1 raises valid during req0's EXEC, then req0 idle → req1_ready first asserted in the IDLE cycle after req0's RESP. alu_a/alu_b keep req0 operands until req1 is accepted.
- req0 asserts valid for one IDLE cycle while req1 is granted (tie, last=0), then drops → only req1 is served; no response for req0.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// ----------------------------------------------------------------------------
// alu_share_arb_if
// Bundles every signal between the shared-ALU arbiter and its neighbours:
// the two requesters, the external combinational ALU and the response bus.
//
//   req0_valid/ctl/a/b  requester 0 operation (ctl: 000 AND, 001 OR, 010 ADD,
//                       110 SUB, 111 SLT)
//   req0_ready          requester 0 accepted this cycle
//   req1_*              same as requester 0
//   alu_ctl/a/b         registered operation driven to the ALU
//   alu_result/zero     combinational ALU outputs
//   rsp0_valid          one-cycle response pulse for requester 0
//   rsp1_valid          one-cycle response pulse for requester 1
//   rsp_result/zero     captured ALU outputs, shared by both responses
//   rsp_err             illegal control code, qualified by rspN_valid
//
// The slave modport is the arbiter's view; master is the environment's view.
// ----------------------------------------------------------------------------
interface alu_share_arb_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic [2:0]       req0_ctl;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [2:0]       req1_ctl;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic [2:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_ctl, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_ctl, req1_a, req1_b,
        output req1_ready,
        output alu_ctl, alu_a, alu_b,
        input  alu_result, alu_zero,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err
    );

    modport master (
        output req0_valid, req0_ctl, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_ctl, req1_a, req1_b,
        input  req1_ready,
        input  alu_ctl, alu_a, alu_b,
        output alu_result, alu_zero,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_arb.sv
// ----------------------------------------------------------------------------
// alu_share_arb
// Shares one external combinational ALU between two requesters. A round-robin
// arbiter accepts one operation, registers its operands onto the ALU inputs,
// captures the ALU outputs one cycle later and returns them to the winner
// with a single-cycle response pulse. Illegal control codes return an error
// flag with a zero result instead of whatever the ALU produced.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    alu_share_arb_if.slave: requester handshakes, ALU drive/return,
//          response pulses and captured result/zero/err
// ----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_share_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic             r_last;
    logic             r_owner;
    logic [2:0]       r_aluCtl;
    logic [WIDTH-1:0] r_aluA;
    logic [WIDTH-1:0] r_aluB;
    logic [WIDTH-1:0] r_rspResult;
    logic             r_rspZero;
    logic             r_rspErr;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_ctlLegal;

    // Round-robin grant. Only offered while idle and out of reset; on a tie
    // the requester that was not served last wins, so r_last=1 after reset
    // hands the first tie to requester 0. At most one grant is ever high.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == IDLE && !reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_grant0 = r_last;
                w_grant1 = ~r_last;
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end
    end

    assign w_accept = w_grant0 | w_grant1;

    // Only the five real ALU operations are legal; 011, 100 and 101 are
    // flagged so the ALU output for them never reaches a requester.
    always_comb begin
        w_ctlLegal = 1'b0;
        case (r_aluCtl)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: w_ctlLegal = 1'b1;
            default:                                w_ctlLegal = 1'b0;
        endcase
    end

    // State register. Reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fixed three-cycle walk: accept, drive the ALU for one cycle, respond.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = EXEC;
            EXEC:    w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Operand latch on accept and result capture at the end of EXEC. The ALU
    // operands are deliberately left in place after the response so the ALU
    // inputs only move when a new operation is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_aluCtl    <= 3'b000;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_rspResult <= '0;
            r_rspZero   <= 1'b0;
            r_rspErr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_aluCtl <= w_grant1 ? bus.req1_ctl : bus.req0_ctl;
                r_aluA   <= w_grant1 ? bus.req1_a   : bus.req0_a;
                r_aluB   <= w_grant1 ? bus.req1_b   : bus.req0_b;
                r_owner  <= w_grant1;
                r_last   <= w_grant1;
            end
            if (r_state == EXEC) begin
                if (w_ctlLegal) begin
                    r_rspResult <= bus.alu_result;
                    r_rspZero   <= bus.alu_zero;
                    r_rspErr    <= 1'b0;
                end else begin
                    r_rspResult <= '0;
                    r_rspZero   <= 1'b0;
                    r_rspErr    <= 1'b1;
                end
            end
        end
    end

    // Handshake and response outputs. Both are masked while reset is high so
    // nothing is offered or reported in the reset cycle itself.
    always_comb begin
        bus.req0_ready = w_grant0;
        bus.req1_ready = w_grant1;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        if (r_state == RESP && !reset) begin
            bus.rsp0_valid = ~r_owner;
            bus.rsp1_valid = r_owner;
        end
    end

    assign bus.alu_ctl    = r_aluCtl;
    assign bus.alu_a      = r_aluA;
    assign bus.alu_b      = r_aluB;
    assign bus.rsp_result = r_rspResult;
    assign bus.rsp_zero   = r_rspZero;
    assign bus.rsp_err    = r_rspErr;

endmodule
